// File: rtl/countdown_fsm_if.sv
// Control and display bundle between the egg-timer core and its user (panel or bench).
// Latency: none, wires only; every register sits in countdown_fsm.
// Backpressure: none; the panel drives commands level-sensitive, the timer always accepts.
//
// Signals
//  load/load_min/load_sec  preset request and BCD mm:ss preset
//  start/pause/ack         run control commands
//  min_bcd/sec_bcd         current BCD count (registered in the core)
//  running/alarm/state     status flags and encoded FSM state
interface countdown_fsm_if;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic       ack;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       alarm;
    logic [1:0] state;

    // Panel side: issues commands and reads the display.
    modport master (
        output load, load_min, load_sec, start, pause, ack,
        input  min_bcd, sec_bcd, running, alarm, state
    );

    // Timer side: consumes commands and drives the display.
    modport slave (
        input  load, load_min, load_sec, start, pause, ack,
        output min_bcd, sec_bcd, running, alarm, state
    );
endinterface

// File: rtl/countdown_fsm.sv
// Down-counting BCD mm:ss egg timer with alarm hold; alarm clears on ack or after ALARM_SECS.
// Latency: 1 sec_clk edge from a sampled command to every output; all outputs registered.
// Backpressure: none; commands are level-sampled each edge, ack > pause > start > load.
//
// Ports
//  sec_clk  1 Hz timebase; every interface input is synchronous to it
//  rst      asynchronous, active-high reset
//  tmr      countdown_fsm_if.slave: load/load_min/load_sec/start/pause/ack in,
//           min_bcd/sec_bcd/running/alarm/state out
module countdown_fsm #(
    parameter int ALARM_SECS = 30,
    parameter int ACW        = 5
) (
    input  logic          sec_clk,
    input  logic          rst,
    countdown_fsm_if.slave tmr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ALARM  = 2'd3
    } state_t;

    // Last alarm-counter value before the automatic return to IDLE.
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_SECS - 1);

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     min_q;
    logic [7:0]     min_d;
    logic [7:0]     sec_q;
    logic [7:0]     sec_d;
    logic [ACW-1:0] actr_q;
    logic [ACW-1:0] actr_d;
    logic           running_q;
    logic           alarm_q;

    logic           count_zero;
    logic           count_one;
    logic [15:0]    count_dec;

    // Clamp one BCD digit to an upper limit (9 for most digits, 5 for seconds tens).
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second BCD decrement of {min_tens, min_units, sec_tens, sec_units}.
    // Borrow ripples units -> tens; seconds tens wraps to 5, minute digits to 9.
    // Never called with 00:00, so the minute-tens digit cannot underflow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        {mt, mu, st, su} = c;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign count_one  = (min_q == 8'h00) && (sec_q == 8'h01);
    assign count_dec  = bcd_dec({min_q, sec_q});

    // Next-state and next-count logic.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        actr_d  = actr_q;

        case (state_q)
            IDLE: begin
                // ack and pause do nothing here but still outrank start/load.
                if (!tmr.ack && !tmr.pause) begin
                    if (tmr.start) begin
                        // A zero preset would alarm instantly; refuse to start.
                        if (!count_zero) begin
                            state_d = RUN;
                        end
                    end else if (tmr.load) begin
                        min_d = {clamp_digit(tmr.load_min[7:4], 4'd9),
                                 clamp_digit(tmr.load_min[3:0], 4'd9)};
                        sec_d = {clamp_digit(tmr.load_sec[7:4], 4'd5),
                                 clamp_digit(tmr.load_sec[3:0], 4'd9)};
                    end
                end
            end

            RUN: begin
                if (tmr.ack) begin
                    state_d = IDLE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (tmr.pause) begin
                    state_d = PAUSED;
                end else if (count_zero) begin
                    // Unreachable in normal use; go straight to alarm rather than wrap.
                    state_d = ALARM;
                    actr_d  = '0;
                end else begin
                    {min_d, sec_d} = count_dec;
                    if (count_one) begin
                        state_d = ALARM;
                        actr_d  = '0;
                    end
                end
            end

            PAUSED: begin
                if (tmr.ack) begin
                    state_d = IDLE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (!tmr.pause && tmr.start) begin
                    state_d = RUN;
                end
            end

            ALARM: begin
                min_d = 8'h00;
                sec_d = 8'h00;
                if (tmr.ack || (actr_q == ALARM_LAST)) begin
                    state_d = IDLE;
                    actr_d  = '0;
                end else begin
                    actr_d = actr_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                min_d   = 8'h00;
                sec_d   = 8'h00;
                actr_d  = '0;
            end
        endcase
    end

    // State, count and status flags; flags are decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge sec_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            actr_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            actr_q    <= actr_d;
            running_q <= (state_d == RUN);
            alarm_q   <= (state_d == ALARM);
        end
    end

    assign tmr.min_bcd = min_q;
    assign tmr.sec_bcd = sec_q;
    assign tmr.running = running_q;
    assign tmr.alarm   = alarm_q;
    assign tmr.state   = state_q;

endmodule

// File: tb/tb_countdown_fsm.sv
// Directed bench for countdown_fsm: stimulus pushes the expected post-edge view into a
// queue, a separate monitor pops and compares one entry after each sec_clk rising edge.
module tb_countdown_fsm;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PAU  = 2'd2;
    localparam logic [1:0] S_ALM  = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       alm;
    } obs_t;

    logic sec_clk = 1'b0;
    logic rst     = 1'b0;

    countdown_fsm_if tif();

    countdown_fsm #(.ALARM_SECS(30), .ACW(5)) dut (
        .sec_clk (sec_clk),
        .rst     (rst),
        .tmr     (tif)
    );

    always #5 sec_clk = ~sec_clk;

    obs_t exp_q[$];
    int   tag_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   step_no = 0;
    obs_t mon_e;
    int   mon_t;

    function automatic obs_t mk(input logic [1:0] s, input logic [7:0] m, input logic [7:0] c);
        obs_t o;
        o.st  = s;
        o.mn  = m;
        o.sc  = c;
        o.run = (s == S_RUN);
        o.alm = (s == S_ALM);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st  = tif.state;
        o.mn  = tif.min_bcd;
        o.sc  = tif.sec_bcd;
        o.run = tif.running;
        o.alm = tif.alarm;
        return o;
    endfunction

    task automatic compare(input string name, input int tag, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got state=%0d %h:%h run=%b alarm=%b, want state=%0d %h:%h run=%b alarm=%b",
                     name, tag, got.st, got.mn, got.sc, got.run, got.alm,
                     exp.st, exp.mn, exp.sc, exp.run, exp.alm);
        end
    endtask

    // Monitor: one expectation per stimulus step, checked just after the edge it targets.
    always @(posedge sec_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            compare("edge", mon_t, sample(), mon_e);
        end
    end

    // Drive one cycle of inputs and queue the state expected after the following edge.
    task automatic step(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                        input logic s, input logic p, input logic a,
                        input logic [1:0] es, input logic [7:0] em, input logic [7:0] ec);
        @(negedge sec_clk);
        tif.load     = ld;
        tif.load_min = lm;
        tif.load_sec = ls;
        tif.start    = s;
        tif.pause    = p;
        tif.ack      = a;
        step_no++;
        exp_q.push_back(mk(es, em, ec));
        tag_q.push_back(step_no);
    endtask

    task automatic idle(input logic [1:0] es, input logic [7:0] em, input logic [7:0] ec);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, es, em, ec);
    endtask

    // Count 00:01 down into ALARM; then either hold the full 30 edges or ack on edge ack_at.
    task automatic alarm_run(input int ack_at);
        step(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h01);
        idle(S_ALM, 8'h00, 8'h00);
        for (int i = 1; i < 30; i++) begin
            if (i == ack_at) begin
                step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);
                return;
            end else if (i == 10) begin
                // start/pause/load are all ignored while alarming.
                step(1'b1, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, S_ALM, 8'h00, 8'h00);
            end else begin
                idle(S_ALM, 8'h00, 8'h00);
            end
        end
        idle(S_IDLE, 8'h00, 8'h00);
    endtask

    initial begin
        tif.load     = 1'b0;
        tif.load_min = 8'h00;
        tif.load_sec = 8'h00;
        tif.start    = 1'b0;
        tif.pause    = 1'b0;
        tif.ack      = 1'b0;

        #1 rst = 1'b1;
        #2 compare("reset", 0, sample(), mk(S_IDLE, 8'h00, 8'h00));
        repeat (2) @(negedge sec_clk);
        rst = 1'b0;

        // 1: basic countdown into alarm
        step(1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h03);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h03);
        idle(S_RUN, 8'h00, 8'h02);
        idle(S_RUN, 8'h00, 8'h01);
        idle(S_ALM, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);

        // 2: multi-digit borrows
        step(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h01, 8'h00);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h01, 8'h00);
        idle(S_RUN, 8'h00, 8'h59);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);
        step(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h10, 8'h00);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h10, 8'h00);
        idle(S_RUN, 8'h09, 8'h59);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);

        // 3: preset clamping
        step(1'b1, 8'h3B, 8'h6A, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h39, 8'h59);
        step(1'b1, 8'hAF, 8'h7C, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h99, 8'h59);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h99, 8'h59);
        idle(S_RUN, 8'h99, 8'h58);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);

        // 4: pause / resume / abort from pause
        step(1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h10);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h10);
        idle(S_RUN, 8'h00, 8'h09);
        idle(S_RUN, 8'h00, 8'h08);
        idle(S_RUN, 8'h00, 8'h07);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, S_PAU,  8'h00, 8'h07);
        idle(S_PAU, 8'h00, 8'h07);
        idle(S_PAU, 8'h00, 8'h07);
        step(1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, S_PAU,  8'h00, 8'h07);
        idle(S_PAU, 8'h00, 8'h07);
        idle(S_PAU, 8'h00, 8'h07);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h07);
        idle(S_RUN, 8'h00, 8'h06);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, S_PAU,  8'h00, 8'h06);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 8'h00, 8'h00);

        // 5: alarm hold time, early ack, counter cleared for the next alarm, zero start
        alarm_run(0);
        alarm_run(4);
        alarm_run(0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h00);

        // 6: priority in RUN and asynchronous reset mid-run
        step(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h05);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h05);
        idle(S_RUN, 8'h00, 8'h04);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, S_PAU,  8'h00, 8'h04);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h04);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, S_IDLE, 8'h00, 8'h00);
        step(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 8'h05);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, S_RUN,  8'h00, 8'h05);
        idle(S_RUN, 8'h00, 8'h04);
        @(negedge sec_clk);
        tif.start = 1'b0;
        #2 rst = 1'b1;
        #1 compare("async_rst", step_no, sample(), mk(S_IDLE, 8'h00, 8'h00));
        #1 rst = 1'b0;
        idle(S_IDLE, 8'h00, 8'h00);

        repeat (3) @(posedge sec_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
